// File: rtl/data_bus.sv
`timescale 1ns/1ps
// data_bus: memory-mapped data slave for the core's data port.
// Holds a word-addressed data RAM (read-before-write, one-cycle read latency),
// a transmit-only 8N1 UART, an 8-bit LED register and a free-running cycle
// counter. The counter is only built when DATA_BUS_TIMER_EN is defined;
// otherwise its register reads as 0 and writes to it are ignored.
module data_bus #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic [7:0]  leds
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // ---------------------------------------------------------------------------
  // Address decode: bit 31 splits RAM from MMIO; MMIO aliases every 16 bytes.
  // ---------------------------------------------------------------------------
  logic          sel_ram;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_ram;
  logic          wr_tx;
  logic          wr_led;
  logic          unused_addr_bits;

  assign sel_ram = ~mem_addr[31];
  assign reg_sel = mem_addr[3:2];
  assign ram_idx = mem_addr[AW+1:2];
  assign wr_ram  = mem_write & sel_ram;
  assign wr_tx   = mem_write & ~sel_ram & (reg_sel == 2'd0);
  assign wr_led  = mem_write & ~sel_ram & (reg_sel == 2'd3);

  // Byte offset and the RAM alias bits carry no meaning here.
  assign unused_addr_bits = ^{mem_addr[30:AW+2], mem_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Data RAM: no reset so it maps onto block RAM; read returns the old word.
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem [RAM_WORDS];
  logic [31:0] ram_rdata_q;

  // Block RAM write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram_mem[ram_idx] <= mem_wdata;
    end
    ram_rdata_q <= ram_mem[ram_idx];
  end

  // ---------------------------------------------------------------------------
  // Cycle counter (optional).
  // ---------------------------------------------------------------------------
  logic [31:0] cnt_rd;

`ifdef DATA_BUS_TIMER_EN
  logic        wr_cnt;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign wr_cnt = mem_write & ~sel_ram & (reg_sel == 2'd2);

  // A store loads the counter and replaces that cycle's increment.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (wr_cnt) begin
      cnt_d = mem_wdata;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = '0;
`endif

  // ---------------------------------------------------------------------------
  // LED register.
  // ---------------------------------------------------------------------------
  logic [7:0] leds_q;
  logic [7:0] leds_d;

  // LED register holds its value until stored to.
  always_comb begin
    leds_d = leds_q;
    if (wr_led) begin
      leds_d = mem_wdata[7:0];
    end
  end

  // LED flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q <= '0;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;

  // ---------------------------------------------------------------------------
  // UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit.
  // ---------------------------------------------------------------------------
  uart_state_e   state_q;
  uart_state_e   state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [2:0]    bit_idx_q;
  logic [2:0]    bit_idx_d;
  logic [7:0]    tx_byte_q;
  logic [7:0]    tx_byte_d;
  logic          bit_done;
  logic          uart_busy;

  assign bit_done = (timer_q == BIT_LAST);

  // UART state register; reset forces IDLE so the line returns high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= UART_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // UART next-state: timer restarts on every state or bit change.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    tx_byte_d = tx_byte_q;
    case (state_q)
      UART_IDLE: begin
        timer_d = '0;
        if (wr_tx) begin
          state_d   = UART_START;
          tx_byte_d = mem_wdata[7:0];
          bit_idx_d = '0;
        end
      end
      UART_START: begin
        if (bit_done) begin
          state_d   = UART_DATA;
          timer_d   = '0;
          bit_idx_d = '0;
        end
      end
      UART_DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      UART_STOP: begin
        if (bit_done) begin
          state_d = UART_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = UART_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // UART outputs: serial line level and busy flag from the current state.
  always_comb begin
    uart_tx   = 1'b1;
    uart_busy = 1'b1;
    case (state_q)
      UART_IDLE:  uart_busy = 1'b0;
      UART_START: uart_tx   = 1'b0;
      UART_DATA:  uart_tx   = tx_byte_q[bit_idx_q];
      UART_STOP:  uart_tx   = 1'b1;
      default:    uart_busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path: MMIO data and the RAM/MMIO select are registered alongside the
  // RAM read so mem_rdata lines up one cycle after the address.
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rdata_q;
  logic [31:0] mmio_rdata_d;
  logic        rd_ram_q;
  logic        rd_ram_d;

  // MMIO read mux; counter and busy are sampled before this edge updates them.
  always_comb begin
    rd_ram_d     = sel_ram;
    mmio_rdata_d = '0;
    case (reg_sel)
      2'd0:    mmio_rdata_d = '0;
      2'd1:    mmio_rdata_d = {31'b0, uart_busy};
      2'd2:    mmio_rdata_d = cnt_rd;
      2'd3:    mmio_rdata_d = {24'b0, leds_q};
      default: mmio_rdata_d = '0;
    endcase
  end

  // Read-path registers; rd_ram_q clears on reset so mem_rdata starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_rdata_q <= '0;
      rd_ram_q     <= 1'b0;
    end else begin
      mmio_rdata_q <= mmio_rdata_d;
      rd_ram_q     <= rd_ram_d;
    end
  end

  assign mem_rdata = rd_ram_q ? ram_rdata_q : mmio_rdata_q;

endmodule

// File: tb/tb_data_bus.sv
`timescale 1ns/1ps
// tb_data_bus: directed plus randomized stimulus against a behavioural model
// of the data bus (RAM contents, LED value, counter as base+elapsed cycles,
// UART frame as a start step and byte).
module tb_data_bus;

  localparam int RAM_WORDS = 1024;
  localparam int CPB       = 4;
  localparam int FRAME     = 10 * CPB;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic [7:0]  leds;

  data_bus #(
    .RAM_WORDS   (RAM_WORDS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .uart_tx  (uart_tx),
    .leds     (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  logic [31:0] mem_model [int];
  logic [7:0]  led_m;
  logic [31:0] cnt_base;
  int          cnt_step;
  bit          frame_valid;
  int          frame_k;
  logic [7:0]  frame_byte;

  function automatic logic model_busy(int j);
    return frame_valid && (j >= frame_k + 1) && (j <= frame_k + FRAME);
  endfunction

  // Line level after the edge of step j.
  function automatic logic model_tx(int j);
    int f;
    if (frame_valid && (j >= frame_k) && (j < frame_k + FRAME)) begin
      f = (j - frame_k) / CPB;
      if (f == 0) return 1'b0;
      if (f == 9) return 1'b1;
      return frame_byte[f-1];
    end
    return 1'b1;
  endfunction

  // Counter value held during step j.
  function automatic logic [31:0] model_cnt(int j);
`ifdef DATA_BUS_TIMER_EN
    return cnt_base + 32'(j - cnt_step);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    led_m       = 8'h00;
    frame_valid = 1'b0;
    cnt_base    = 32'd0;
    cnt_step    = cyc;
  endtask

  // One bus cycle: predict, drive, clock, compare.
  task automatic step(input logic [31:0] a, input logic [31:0] w, input logic we);
    logic [31:0] exp_rd;
    bit          known;
    int          idx;
    int          rsel;
    known  = 1'b1;
    exp_rd = 32'd0;
    idx    = int'((a >> 2) % RAM_WORDS);
    rsel   = int'((a >> 2) & 32'd3);
    if (a < 32'h8000_0000) begin
      if (mem_model.exists(idx)) exp_rd = mem_model[idx];
      else known = 1'b0;
    end else begin
      case (rsel)
        1:       exp_rd = {31'd0, model_busy(cyc)};
        2:       exp_rd = model_cnt(cyc);
        3:       exp_rd = {24'd0, led_m};
        default: exp_rd = 32'd0;
      endcase
    end
    if (we) begin
      if (a < 32'h8000_0000) begin
        mem_model[idx] = w;
      end else begin
        case (rsel)
          0: if (!model_busy(cyc)) begin
               frame_valid = 1'b1;
               frame_k     = cyc;
               frame_byte  = w[7:0];
             end
          2: begin
`ifdef DATA_BUS_TIMER_EN
               cnt_base = w;
               cnt_step = cyc + 1;
`endif
             end
          3: led_m = w[7:0];
          default: ;
        endcase
      end
    end
    mem_addr  = a;
    mem_wdata = w;
    mem_write = we;
    @(posedge clk);
    #1;
    if (known) check("rdata", mem_rdata, exp_rd);
    check("uart_tx", {31'd0, uart_tx}, {31'd0, model_tx(cyc)});
    check("leds", {24'd0, leds}, {24'd0, led_m});
    mem_write = 1'b0;
    cyc++;
  endtask

  function automatic logic [31:0] rand_mmio(int r);
    return 32'h8000_0000 | ($urandom & 32'h7FFF_FFF0) | (32'(r) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog step=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] exp_cnt;
    int          kind;
    reset     = 1'b1;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Reset state
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_leds", {24'd0, leds}, 32'd0);
    step(32'h8000_0004, 32'd0, 1'b0);
    check("rst_status", mem_rdata, 32'd0);

    // RAM write/read and alias
    step(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    step(32'h0000_0010, 32'd0, 1'b0);
    check("ram_rd", mem_rdata, 32'hDEAD_BEEF);
    step(32'h0000_1010, 32'd0, 1'b0);
    check("ram_alias", mem_rdata, 32'hDEAD_BEEF);

    // Read-before-write
    step(32'h0000_0020, 32'h0000_0000, 1'b1);
    step(32'h0000_0020, 32'h1234_5678, 1'b1);
    check("rbw_old", mem_rdata, 32'h0000_0000);
    step(32'h0000_0020, 32'd0, 1'b0);
    check("rbw_new", mem_rdata, 32'h1234_5678);

    // UART frame 0xA5 with a dropped write at cycle 10
    step(32'h8000_0000, 32'h0000_00A5, 1'b1);
    for (int i = 1; i <= FRAME + 4; i++) begin
      if (i == 10) step(32'h8000_0000, 32'h0000_003C, 1'b1);
      else         step(32'h8000_0004, 32'd0, 1'b0);
    end
    check("status_after", mem_rdata, 32'd0);

    // Counter wrap
    step(32'h8000_0008, 32'hFFFF_FFFE, 1'b1);
    repeat (3) step(32'h8000_000C, 32'd0, 1'b0);
    step(32'h8000_0008, 32'd0, 1'b0);
`ifdef DATA_BUS_TIMER_EN
    exp_cnt = 32'h0000_0001;
`else
    exp_cnt = 32'h0000_0000;
`endif
    check("cnt_wrap", mem_rdata, exp_cnt);

    // LEDs
    step(32'h8000_000C, 32'hFFFF_FF5A, 1'b1);
    step(32'h8000_001C, 32'd0, 1'b0);
    check("led_rd", mem_rdata, 32'h0000_005A);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: begin
          a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(64, 127)) << 2) | 32'($urandom_range(0, 3));
          step(a, $urandom, 1'b1);
        end
        3, 4: begin
          a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(64, 127)) << 2) | 32'($urandom_range(0, 3));
          step(a, 32'd0, 1'b0);
        end
        5: step(rand_mmio(0), $urandom, ($urandom_range(0, 3) == 0));
        6: step(rand_mmio(1), $urandom, $urandom_range(0, 1) == 1);
        7: step(rand_mmio(2), $urandom, ($urandom_range(0, 3) == 0));
        8: step(rand_mmio(3), $urandom, $urandom_range(0, 1) == 1);
        default: step(rand_mmio(0), 32'd0, 1'b0);
      endcase
    end

    // Reset mid-frame
    repeat (FRAME + 2) step(32'h8000_0004, 32'd0, 1'b0);
    step(32'h8000_0000, 32'h0000_0000, 1'b1);
    repeat (6) step(32'h8000_0004, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_rdata", mem_rdata, 32'd0);
    check("midrst_leds", {24'd0, leds}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(32'h8000_0004, 32'd0, 1'b0);
    check("post_status", mem_rdata, 32'd0);
    step(32'h0000_0010, 32'd0, 1'b0);
    check("post_ram", mem_rdata, 32'hDEAD_BEEF);
    repeat (4) step(32'h8000_0008, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
